// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM encodings, port ids, latched access record.
// Also used by other shared-resource arbiters built on rr_arb2.
package dmem_arbiter_pkg;

  localparam int DEPTH_DEF = 64;
  localparam int AW_DEF    = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DBG  = 1'b1;

  // One accepted access, frozen on the granting edge.
  typedef struct packed {
    logic        port;
    logic        we;
    logic        err;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester handshakes plus the single-port memory bus.
// slave = arbiter view, master = requesters/memory view.
interface dmem_arbiter_if;

  logic        req0;
  logic        we0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        gnt0;
  logic        rvalid0;
  logic [31:0] rdata0;
  logic        err0;

  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        gnt1;
  logic        rvalid1;
  logic [31:0] rdata1;
  logic        err1;

  logic        mem_we;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  modport slave (
    input  req0, we0, addr0, wdata0,
    output gnt0, rvalid0, rdata0, err0,
    input  req1, we1, addr1, wdata1,
    output gnt1, rvalid1, rdata1, err1,
    output mem_we, mem_a, mem_wd,
    input  mem_rd
  );

  modport master (
    output req0, we0, addr0, wdata0,
    input  gnt0, rvalid0, rdata0, err0,
    output req1, we1, addr1, wdata1,
    input  gnt1, rvalid1, rdata1, err1,
    input  mem_we, mem_a, mem_wd,
    output mem_rd
  );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone requester wins, on contention the port that was not granted last wins.
// Purely combinational, zero latency; the caller owns last_grant and the hold-until-grant handshake.
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    if (i_req[0] && (!i_req[1] || (i_last_grant == PORT_DBG))) begin
      o_gnt[0] = 1'b1;
    end else if (i_req[1]) begin
      o_gnt[1] = 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the single-port data memory; grant combinational, response pulse 2 cycles after grant.
// Requests are held until gnt; at most one access in flight, peak one access per 2 cycles.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic           clk,
  input  logic           reset,
  dmem_arbiter_if.slave  bus
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_last_grant;
  op_t         r_op;
  op_t         w_op_nxt;
  logic        w_grant_en;
  logic [1:0]  w_req;
  logic [1:0]  w_gnt;
  logic [31:0] w_rsp_data;
  logic [1:0]  r_rvalid;
  logic [1:0]  r_err;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;

  // Misaligned, or word index beyond the attached array (DEPTH need not be a power of two).
  function automatic logic f_addr_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:AW+2] != '0) ||
           ({1'b0, a[AW+1:2]} >= (AW+1)'(DEPTH));
  endfunction

  assign w_grant_en = (r_state == ST_IDLE) || (r_state == ST_RESP);
  assign w_req      = {bus.req1, bus.req0} & {2{w_grant_en}};

  rr_arb2 u_rr_arb2 (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_gnt        (w_gnt)
  );

  always_comb begin
    w_op_nxt = '0;
    if (w_gnt[1]) begin
      w_op_nxt.port  = PORT_DBG;
      w_op_nxt.we    = bus.we1;
      w_op_nxt.addr  = bus.addr1;
      w_op_nxt.wdata = bus.wdata1;
    end else begin
      w_op_nxt.port  = PORT_CORE;
      w_op_nxt.we    = bus.we0;
      w_op_nxt.addr  = bus.addr0;
      w_op_nxt.wdata = bus.wdata0;
    end
    w_op_nxt.err = f_addr_bad(w_op_nxt.addr);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (|w_gnt) w_state_nxt = ST_ACCESS;
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = (|w_gnt) ? ST_ACCESS : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // last_grant resets to the debug port so the core wins the first contention.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op         <= '0;
      r_last_grant <= PORT_DBG;
    end else if (|w_gnt) begin
      r_op         <= w_op_nxt;
      r_last_grant <= w_gnt[1];
    end
  end

  assign w_rsp_data = (r_op.err || r_op.we) ? '0 : bus.mem_rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rvalid <= 2'b00;
      r_err    <= 2'b00;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_rvalid <= 2'b00;
      r_err    <= 2'b00;
      if (r_state == ST_ACCESS) begin
        r_rvalid[r_op.port] <= 1'b1;
        r_err[r_op.port]    <= r_op.err;
        if (r_op.port == PORT_CORE) begin
          r_rdata0 <= w_rsp_data;
        end else begin
          r_rdata1 <= w_rsp_data;
        end
      end
    end
  end

  assign bus.gnt0    = w_gnt[0];
  assign bus.gnt1    = w_gnt[1];
  assign bus.rvalid0 = r_rvalid[0];
  assign bus.rvalid1 = r_rvalid[1];
  assign bus.err0    = r_err[0];
  assign bus.err1    = r_err[1];
  assign bus.rdata0  = r_rdata0;
  assign bus.rdata1  = r_rdata1;

  // Registers only feed the memory bus, so reset kills mem_we without waiting for a clock.
  assign bus.mem_we  = (r_state == ST_ACCESS) && r_op.we && !r_op.err;
  assign bus.mem_a   = r_op.addr;
  assign bus.mem_wd  = r_op.wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: per-port request queues, response scoreboard, reference memory image.
module tb_dmem_arbiter;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  typedef struct {
    int          port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic mem_init;
  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.DEPTH(64), .AW(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  assign bus.mem_rd = mem[bus.mem_a[7:2]];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h1000_0000 + 32'(i);
    end else if (bus.mem_we) begin
      mem[bus.mem_a[7:2]] <= bus.mem_wd;
    end
  end

  req_t q0[$];
  req_t q1[$];
  exp_t sb[$];
  int   glog_port[$];
  int   glog_cyc[$];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic        e_act = 1'b0;
  logic        e_we = 1'b0;
  logic [31:0] e_a = '0;
  logic [31:0] e_wd = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic bad_addr(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
  endfunction

  task automatic drive();
    bus.req0 = (q0.size() != 0);
    bus.req1 = (q1.size() != 0);
    if (q0.size() != 0) begin
      bus.we0 = q0[0].we; bus.addr0 = q0[0].addr; bus.wdata0 = q0[0].wdata;
    end else begin
      bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    end
    if (q1.size() != 0) begin
      bus.we1 = q1[0].we; bus.addr1 = q1[0].addr; bus.wdata1 = q1[0].wdata;
    end else begin
      bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    end
  endtask

  task automatic check_rsp(input int p, input logic v, input logic [31:0] d, input logic err);
    exp_t e;
    if (v) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", 32'(v), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rsp_port", 32'(p), 32'(e.port));
        chk("rsp_data", d, e.rdata);
        chk("rsp_err", 32'(err), 32'(e.err));
        chk("rsp_latency", 32'(cyc - e.cyc), 32'd2);
        if (e.we && !e.err) ref_mem[e.addr[7:2]] = e.wdata;
      end
    end
  endtask

  task automatic take(input int p);
    req_t o;
    exp_t e;
    int   qs;
    qs = (p == 0) ? q0.size() : q1.size();
    chk("gnt_req_pending", 32'(qs != 0), 32'd1);
    if (qs != 0) begin
      o = (p == 0) ? q0.pop_front() : q1.pop_front();
      e.port  = p;
      e.we    = o.we;
      e.addr  = o.addr;
      e.wdata = o.wdata;
      e.err   = bad_addr(o.addr);
      e.rdata = (e.err || o.we) ? 32'd0 : ref_mem[o.addr[7:2]];
      e.cyc   = cyc;
      sb.push_back(e);
      glog_port.push_back(p);
      glog_cyc.push_back(cyc);
      e_act = 1'b1;
      e_a   = o.addr;
      e_wd  = o.wdata;
      e_we  = o.we && !e.err;
    end
  endtask

  task automatic monitor();
    logic g0, g1;
    g0 = bus.gnt0;
    g1 = bus.gnt1;
    chk("gnt_onehot", 32'(g0 & g1), 32'd0);
    chk("mem_we", 32'(bus.mem_we), 32'(e_we));
    if (e_act) begin
      chk("mem_a", bus.mem_a, e_a);
      if (e_we) chk("mem_wd", bus.mem_wd, e_wd);
    end
    e_act = 1'b0;
    e_we  = 1'b0;
    check_rsp(0, bus.rvalid0, bus.rdata0, bus.err0);
    check_rsp(1, bus.rvalid1, bus.rdata1, bus.err1);
    if (sb.size() != 0 && cyc > sb[0].cyc + 2) begin
      chk("rsp_missing", 32'(cyc - sb[0].cyc), 32'd2);
      void'(sb.pop_front());
    end
    if (g0) take(0);
    if (g1) take(1);
  endtask

  task automatic step();
    drive();
    #1;
    monitor();
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q0.size() + q1.size() + sb.size()) != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(n < budget), 32'd1);
    step();
    step();
  endtask

  initial begin
    reset = 1'b0;
    mem_init = 1'b1;
    bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
    bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h1000_0000 + 32'(i);
    repeat (2) @(negedge clk);
    mem_init = 1'b0;
    #1;
    chk("rst_gnt0", 32'(bus.gnt0), 32'd0);
    chk("rst_gnt1", 32'(bus.gnt1), 32'd0);
    chk("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
    chk("rst_err0", 32'(bus.err0), 32'd0);
    chk("rst_err1", 32'(bus.err1), 32'd0);
    chk("rst_rdata0", bus.rdata0, 32'd0);
    chk("rst_rdata1", bus.rdata1, 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_mem_a", bus.mem_a, 32'd0);
    chk("rst_mem_wd", bus.mem_wd, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Continuous contention right after reset: core first, then strict alternation.
    glog_port.delete(); glog_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b0, 32'h40 + 32'(4 * i), 32'd0});
      q1.push_back('{1'b0, 32'h80 + 32'(4 * i), 32'd0});
    end
    drain(100);
    chk("cont_ngrants", 32'(glog_port.size()), 32'd8);
    for (int i = 0; i < glog_port.size(); i++) begin
      chk("cont_order", 32'(glog_port[i]), 32'(i % 2));
      if (i > 0) chk("cont_spacing", 32'(glog_cyc[i] - glog_cyc[i-1]), 32'd2);
    end

    // Store on the core port, read back through the debug port.
    q0.push_back('{1'b1, 32'h10, 32'hDEAD_BEEF});
    drain(50);
    q1.push_back('{1'b0, 32'h10, 32'd0});
    drain(50);

    // Misaligned store is rejected; word 4 must still hold the earlier value.
    q1.push_back('{1'b1, 32'h12, 32'hBAD0_BAD0});
    q1.push_back('{1'b0, 32'h10, 32'd0});
    drain(50);

    // Word 64 is out of range (and would alias word 0); word 63 is the last legal one.
    q0.push_back('{1'b1, 32'h100, 32'h5555_AAAA});
    q0.push_back('{1'b1, 32'hFC, 32'hCAFE_F00D});
    q0.push_back('{1'b0, 32'hFC, 32'd0});
    q0.push_back('{1'b0, 32'h0, 32'd0});
    q0.push_back('{1'b0, 32'h100, 32'd0});
    drain(100);

    // Back-to-back loads: each new grant lands in the RESP cycle of the previous access.
    q1.push_back('{1'b1, 32'h0, 32'd1});
    q1.push_back('{1'b1, 32'h4, 32'd2});
    q1.push_back('{1'b1, 32'h8, 32'd3});
    drain(100);
    glog_port.delete(); glog_cyc.delete();
    q0.push_back('{1'b0, 32'h0, 32'd0});
    q0.push_back('{1'b0, 32'h4, 32'd0});
    q0.push_back('{1'b0, 32'h8, 32'd0});
    drain(100);
    chk("b2b_ngrants", 32'(glog_cyc.size()), 32'd3);
    for (int i = 1; i < glog_cyc.size(); i++) begin
      chk("b2b_spacing", 32'(glog_cyc[i] - glog_cyc[i-1]), 32'd2);
    end

    // Reset asserted mid-ACCESS of a store: write and response both abandoned.
    q0.push_back('{1'b1, 32'h20, 32'h0000_1234});
    step();
    chk("abort_we_before", 32'(bus.mem_we), 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_we_async", 32'(bus.mem_we), 32'd0);
    sb.delete();
    e_act = 1'b0;
    e_we  = 1'b0;
    @(negedge clk);
    cyc++;
    reset = 1'b1;
    repeat (3) step();
    glog_port.delete(); glog_cyc.delete();
    q1.push_back('{1'b0, 32'h20, 32'd0});
    step();
    chk("abort_idle_gnt", 32'(glog_port.size()), 32'd1);
    drain(50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
